// File: rtl/uart_pkg.sv
// Shared UART-side definitions: hex_word_tx state encoding, ASCII constants
// and the nibble/ASCII helpers used by both transmit and receive stages.
package uart_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HEX  = 3'd1;
    localparam logic [2:0] ST_CR   = 3'd2;
    localparam logic [2:0] ST_LF   = 3'd3;
    localparam logic [2:0] ST_FIN  = 3'd4;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;

    // Receive-side decode bounds (digits, upper and lower case letters)
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_F     = 8'h46;
    localparam logic [7:0] ASCII_LOW_A = 8'h61;
    localparam logic [7:0] ASCII_LOW_F = 8'h66;

    function automatic logic [7:0] nib_to_ascii(input logic [3:0] nib);
        logic [7:0] wide;
        wide = {4'h0, nib};
        if (nib < 4'd10) begin
            return ASCII_0 + wide;
        end
        return ASCII_A + (wide - 8'd10);
    endfunction

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// Combinational 4-bit value to uppercase ASCII hex character.
module hex_nibble_to_ascii
    import uart_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    assign ascii = nib_to_ascii(nibble);

endmodule

// File: rtl/hex_word_tx.sv
// Serialises a binary word as uppercase ASCII hex (MSB nibble first), optionally
// followed by CR LF, into the UART TX FIFO with tx_full back-pressure.
module hex_word_tx
    import uart_pkg::*;
#(
    parameter int DATA_W    = 66,
    parameter int NIB_N     = (DATA_W + 3) / 4,
    parameter int SEND_CRLF = 1
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic              tx_full,
    output logic              write_uart,
    output logic [7:0]        write_data,
    output logic              busy,
    output logic              done
);

    localparam int SR_W  = 4 * NIB_N;
    localparam int CNT_W = $clog2(NIB_N + 1);

    logic [2:0]       state_reg, state_next;
    logic [SR_W-1:0]  shift_reg, shift_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [7:0]       hex_char;
    logic             sending;
    logic             wr;

    hex_nibble_to_ascii u_nib (
        .nibble (shift_reg[SR_W-1 -: 4]),
        .ascii  (hex_char)
    );

    // A write in the reset cycle would be lost from the FSM's view, so suppress it.
    assign sending = (state_reg == ST_HEX) || (state_reg == ST_CR) || (state_reg == ST_LF);
    assign wr      = sending && !tx_full && !reset;

    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    shift_next = SR_W'(data_in);
                    cnt_next   = '0;
                    state_next = ST_HEX;
                end
            end
            ST_HEX: begin
                if (wr) begin
                    shift_next = shift_reg << 4;
                    cnt_next   = cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(NIB_N - 1)) begin
                        state_next = (SEND_CRLF != 0) ? ST_CR : ST_FIN;
                    end
                end
            end
            ST_CR:   if (wr) state_next = ST_LF;
            ST_LF:   if (wr) state_next = ST_FIN;
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            shift_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        write_data = 8'h00;
        case (state_reg)
            ST_HEX:  write_data = hex_char;
            ST_CR:   write_data = ASCII_CR;
            ST_LF:   write_data = ASCII_LF;
            default: write_data = 8'h00;
        endcase
    end

    assign write_uart = wr;
    assign busy       = (state_reg != ST_IDLE);
    assign done       = (state_reg == ST_FIN);

endmodule

// File: tb/tb_hex_word_tx.sv
// Bench for hex_word_tx: vector table, stall/restart/reset sequences and random
// words under random back-pressure checked against a string-formatting model.
module tb_hex_word_tx;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start;
    logic [65:0] data_in;
    logic        tx_full;
    logic        write_uart;
    logic [7:0]  write_data;
    logic        busy;
    logic        done;

    logic        start8;
    logic [7:0]  data8;
    logic        tx_full8;
    logic        write_uart8;
    logic [7:0]  write_data8;
    logic        busy8;
    logic        done8;

    hex_word_tx u_dut (
        .CLK        (clk),
        .reset      (reset),
        .start      (start),
        .data_in    (data_in),
        .tx_full    (tx_full),
        .write_uart (write_uart),
        .write_data (write_data),
        .busy       (busy),
        .done       (done)
    );

    hex_word_tx #(.DATA_W(8), .SEND_CRLF(0)) u_dut8 (
        .CLK        (clk),
        .reset      (reset),
        .start      (start8),
        .data_in    (data8),
        .tx_full    (tx_full8),
        .write_uart (write_uart8),
        .write_data (write_data8),
        .busy       (busy8),
        .done       (done8)
    );

    int compared   = 0;
    int mismatched = 0;

    byte cap_q[$];
    int  first_wr, last_wr, done_cyc, done_cnt, busy_low, stall_wr, stall_bad;
    int  after_busy;

    typedef struct {
        logic [65:0] data;
        string       hex;
    } vec_t;

    vec_t vecs[5];

    localparam logic [65:0] WORD = 66'h3_0123456789ABCDEF;

    function automatic void check(string name, longint act, longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void check_stream(string name, string hex, bit crlf);
        byte   exp_q[$];
        bit    bad;
        string got;
        for (int i = 0; i < hex.len(); i++) exp_q.push_back(hex[i]);
        if (crlf) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
        bad = (exp_q.size() != cap_q.size());
        if (!bad) begin
            for (int i = 0; i < exp_q.size(); i++) if (exp_q[i] != cap_q[i]) bad = 1'b1;
        end
        compared++;
        if (bad) begin
            mismatched++;
            got = "";
            foreach (cap_q[i]) got = {got, $sformatf("%02h ", cap_q[i])};
            $display("FAIL %s: got [%s] expected \"%s\"%s", name, got, hex, crlf ? "+CRLF" : "");
        end
    endfunction

    // Reference: the hex text of the word, zero-padded to its full digit count.
    function automatic string model_hex66(logic [65:0] d);
        string s;
        s = $sformatf("%h", d);
        return s.toupper();
    endfunction

    task automatic run_msg(input logic [65:0] d, input int stall_at, input int stall_len,
                           input int restart_cyc, input bit rand_full);
        int stall_left;
        stall_left = stall_len;
        cap_q.delete();
        first_wr = -1; last_wr = -1; done_cyc = -1; done_cnt = 0;
        busy_low = 0; stall_wr = 0; stall_bad = 0; after_busy = -1;
        start = 1'b1; data_in = d; tx_full = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc < 400; cyc++) begin
            start = (cyc == restart_cyc);
            if (cyc == restart_cyc) data_in = '0;
            if (rand_full) tx_full = ($urandom_range(0, 2) == 0);
            else if (stall_left > 0 && cap_q.size() == stall_at) begin
                tx_full = 1'b1;
                stall_left--;
            end else tx_full = 1'b0;
            @(negedge clk);
            if (tx_full && stall_len > 0) begin
                if (write_uart) stall_wr++;
                if (write_data != 8'h32) stall_bad++;
            end
            if (write_uart) begin
                cap_q.push_back(write_data);
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
            end
            if (done_cnt == 0 && !busy) busy_low++;
            if (done_cnt > 0 && cyc == done_cyc + 1) after_busy = busy;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            @(posedge clk); #1;
            if (done_cnt > 0 && cyc >= done_cyc + 2) break;
        end
        start = 1'b0;
        tx_full = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [65:0] d;

        reset = 1'b1; start = 1'b0; data_in = '0; tx_full = 1'b0;
        start8 = 1'b0; data8 = '0; tx_full8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_write_uart", write_uart, 0);
        check("rst_write_data", write_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst8_write_uart", write_uart8, 0);
        check("rst8_busy", busy8, 0);
        @(posedge clk); #1;

        vecs[0] = '{WORD, "30123456789ABCDEF"};
        vecs[1] = '{{66{1'b1}}, "3FFFFFFFFFFFFFFFF"};
        vecs[2] = '{66'h0, "00000000000000000"};
        vecs[3] = '{66'h1_0000000000000000, "10000000000000000"};
        vecs[4] = '{66'h2_FEDCBA9876543210, "2FEDCBA9876543210"};
        for (int v = 0; v < 5; v++) begin
            run_msg(vecs[v].data, 0, 0, -1, 1'b0);
            $display("vec %0d: data=%h writes=%0d done_cyc=%0d", v, vecs[v].data, cap_q.size(), done_cyc);
            check_stream($sformatf("vec%0d_stream", v), vecs[v].hex, 1'b1);
            check($sformatf("vec%0d_first_wr", v), first_wr, 1);
            check($sformatf("vec%0d_last_wr", v), last_wr, 19);
            check($sformatf("vec%0d_done_cyc", v), done_cyc, 20);
            check($sformatf("vec%0d_done_cnt", v), done_cnt, 1);
            check($sformatf("vec%0d_busy_low", v), busy_low, 0);
            check($sformatf("vec%0d_idle_after", v), after_busy, 0);
        end

        run_msg(WORD, 3, 5, -1, 1'b0);
        $display("stall: writes=%0d done_cyc=%0d", cap_q.size(), done_cyc);
        check_stream("stall_stream", "30123456789ABCDEF", 1'b1);
        check("stall_write_uart", stall_wr, 0);
        check("stall_data_held", stall_bad, 0);
        check("stall_done_cyc", done_cyc, 25);
        check("stall_done_cnt", done_cnt, 1);

        run_msg(WORD, 0, 0, 7, 1'b0);
        $display("restart7: writes=%0d done_cyc=%0d", cap_q.size(), done_cyc);
        check_stream("restart7_stream", "30123456789ABCDEF", 1'b1);
        check("restart7_done_cnt", done_cnt, 1);
        check("restart7_done_cyc", done_cyc, 20);

        run_msg(WORD, 0, 0, 20, 1'b0);
        $display("restart_fin: writes=%0d busy_after=%0d", cap_q.size(), after_busy);
        check_stream("restart_fin_stream", "30123456789ABCDEF", 1'b1);
        check("restart_fin_done_cnt", done_cnt, 1);
        check("restart_fin_idle", after_busy, 0);

        // Reset mid-message after the 10th character.
        n = 0;
        start = 1'b1; data_in = WORD;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 100 && n < 10; c++) begin
            @(negedge clk);
            if (write_uart) n++;
            @(posedge clk); #1;
        end
        check("midrst_writes_before", n, 10);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_wr_in_reset", write_uart, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        n = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (write_uart || done) n++;
        end
        check("midrst_quiet", n, 0);
        $display("midrst: quiet period events=%0d", n);
        @(posedge clk); #1;
        run_msg(WORD, 0, 0, -1, 1'b0);
        check_stream("midrst_resend_stream", "30123456789ABCDEF", 1'b1);
        check("midrst_resend_done_cyc", done_cyc, 20);

        for (int r = 0; r < 12; r++) begin
            d[65:64] = 2'($urandom);
            d[63:32] = $urandom;
            d[31:0]  = $urandom;
            run_msg(d, 0, 0, -1, 1'b1);
            $display("rand %0d: data=%h writes=%0d done_cyc=%0d", r, d, cap_q.size(), done_cyc);
            check_stream($sformatf("rand%0d_stream", r), model_hex66(d), 1'b1);
            check($sformatf("rand%0d_done_cnt", r), done_cnt, 1);
        end

        // Narrow instance: DATA_W=8, no CR LF.
        start8 = 1'b1; data8 = 8'hA5;
        @(posedge clk); #1;
        start8 = 1'b0;
        @(negedge clk);
        $display("w8 cyc1: wr=%0d data=%h", write_uart8, write_data8);
        check("w8_c1_wr", write_uart8, 1);
        check("w8_c1_data", write_data8, 8'h41);
        check("w8_c1_busy", busy8, 1);
        @(posedge clk); #1;
        @(negedge clk);
        $display("w8 cyc2: wr=%0d data=%h", write_uart8, write_data8);
        check("w8_c2_wr", write_uart8, 1);
        check("w8_c2_data", write_data8, 8'h35);
        check("w8_c2_done", done8, 0);
        @(posedge clk); #1;
        @(negedge clk);
        $display("w8 cyc3: wr=%0d done=%0d", write_uart8, done8);
        check("w8_c3_wr", write_uart8, 0);
        check("w8_c3_done", done8, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("w8_c4_busy", busy8, 0);
        check("w8_c4_done", done8, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/hex_word_tx.md
Name: hex_word_tx

Overview:
- Response stage on the UART transmit side. Downstream of the hex-ASCII receive/collect stage, upstream of the uart_top transmit FIFO.
- Takes a wide binary word with a one-cycle start strobe and serialises it as uppercase ASCII hex characters, MSB nibble first, optionally followed by CR LF.
- Pushes the characters into the UART TX FIFO through its write_uart/write_data interface, stalling on tx_full. This lets software read back collected or computed values.

Parameters:
- DATA_W, 66: width of the word to send. Must be at least 1.
- NIB_N, (DATA_W+3)/4: number of hex characters, derived (17 at the default). The top nibble is zero-extended.
- SEND_CRLF, 1: 1 appends 8'h0D then 8'h0A after the hex digits; 0 sends hex digits only.

Ports:
- CLK, input, 1: system clock (100 MHz).
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: one-cycle request; data_in is sampled in the same cycle.
- data_in, input, DATA_W: word to transmit.
- tx_full, input, 1: UART TX FIFO full flag.
- write_uart, output, 1: one-cycle FIFO write strobe.
- write_data, output, 8: ASCII character presented with write_uart.
- busy, output, 1: high from the cycle after start is accepted until done.
- done, output, 1: one-cycle pulse after the last character is written.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high.
- Reset values: state=IDLE, shift register=0, character counter=0. Outputs write_uart=0, write_data=8'h00, busy=0, done=0.
- States: IDLE, HEX, CR, LF, FIN.
- IDLE:
  - If start=1, load data_in (zero-extended to 4*NIB_N bits) into the shift register, clear the counter, go to HEX.
  - If start=0, stay in IDLE.
- HEX:
  - write_data = ASCII of shift register bits [4*NIB_N-1 -: 4]. Values 0-9 map to 8'h30-8'h39; values A-F map to 8'h41-8'h46 (uppercase only).
  - When tx_full=0: assert write_uart, shift the register left by 4, increment the counter.
  - After the write with counter = NIB_N-1, go to CR if SEND_CRLF=1, else to FIN.
- CR: write_data=8'h0D. On the write (tx_full=0), go to LF.
- LF: write_data=8'h0A. On the write (tx_full=0), go to FIN.
- FIN: done=1 for exactly one cycle, then go to IDLE.
- write_uart = (state is HEX, CR or LF) AND NOT tx_full. It is combinational from the registered state and tx_full. There is at most one write per cycle.
- Back-pressure: while tx_full=1, write_uart=0 and state, shift register and counter hold; write_data holds its value. No character is dropped or duplicated.
- busy = state != IDLE.
- start while busy (including the FIN cycle) is ignored, and data_in is not resampled.
- Latency with tx_full held low, start at cycle 0:
  - write_uart high on cycles 1 through NIB_N+2 (19 writes at the defaults).
  - done pulse on cycle NIB_N+3, i.e. cycle 20.
  - busy high on cycles 1 to 20, and start is accepted again from cycle 21.
- Reset asserted mid-message: next cycle is IDLE, no further writes, no done pulse. Characters already written stay in the FIFO.
- DATA_W not a multiple of 4: the leading character reflects the zero-extended upper bits. Example: DATA_W=66 with top bits 2'b11 gives '3'.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding for hex_word_tx;
  - ASCII constants ASCII_CR=8'h0D, ASCII_LF=8'h0A, ASCII_0=8'h30, ASCII_A=8'h41;
  - the nibble-to-ASCII function, shared with the receive-side ASCII-to-nibble decode constants.
- One combinational sub-module, hex_nibble_to_ascii (4-bit in, 8-bit out), instantiated once on the shift-register MSB nibble.

Test Plan:
- Default params, tx_full=0, start with data_in=66'h3_0123456789ABCDEF -> 19 consecutive writes on cycles 1 to 19 carrying "30123456789ABCDEF" then 8'h0D, 8'h0A; done=1 on cycle 20 only; busy high on cycles 1 to 20.
- Same word, tx_full=1 for 5 cycles starting at the 4th character -> write_uart=0 during the stall, write_data held at '2' (8'h32), resumes with '2'; the captured stream is identical; done delayed by 5 cycles.
- start pulsed again with data_in=66'h0 on cycle 7 of a message -> ignored; the captured stream is still the first word; exactly one done pulse.
- reset asserted for 1 cycle after the 10th write -> no further write_uart, busy=0 and done=0 the next cycle; a new start then sends a complete message.
- DATA_W=8, SEND_CRLF=0, data_in=8'hA5 -> writes 8'h41, 8'h35 on cycles 1 and 2; done on cycle 3.
- DATA_W=66, data_in all ones -> first character '3', then 16 'F' (8'h46), then CR LF.
